// File: rtl/simplez_pkg.sv
// Shared definitions for the Simplez core: opcodes, sequencer states and field helpers.
package simplez_pkg;

   localparam int unsigned AW_DEF = 9;
   localparam int unsigned DW_DEF = 12;

   localparam logic [2:0] OP_ST   = 3'd0;
   localparam logic [2:0] OP_LD   = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_BR   = 3'd3;
   localparam logic [2:0] OP_BZ   = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;
   localparam logic [2:0] OP_DEC  = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;

   typedef enum logic [2:0] {
      StInit,
      StFetch,
      StDecode,
      StExec,
      StMem,
      StHalt
   } state_e;

   function automatic logic [2:0] ir_op(input logic [11:0] ir);
      return ir[11:9];
   endfunction

   function automatic logic [8:0] ir_cd(input logic [11:0] ir);
      return ir[8:0];
   endfunction

endpackage

// File: rtl/simplez_alu.sv
// Accumulator update for LD/ADD/CLR/DEC; other opcodes pass the accumulator through.
module simplez_alu
   import simplez_pkg::*;
#(
   parameter int unsigned DW = DW_DEF
) (
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] operand_i,
   input  logic [2:0]    op_i,
   output logic [DW-1:0] a_o,
   output logic          z_o
);

   always_comb begin
      a_o = a_i;
      case (op_i)
         OP_LD:   a_o = operand_i;
         OP_ADD:  a_o = a_i + operand_i;
         OP_CLR:  a_o = '0;
         OP_DEC:  a_o = a_i - DW'(1);
         default: a_o = a_i;
      endcase
      z_o = (a_o == '0);
   end

endmodule

// File: rtl/simplez_cpu.sv
// Simplez core: sequencer, PC/IR and accumulator. Optional single-step gating of FETCH
// is enabled by defining SIMPLEZ_STEP_EN (adds the step input).
module simplez_cpu
   import simplez_pkg::*;
#(
   parameter logic [8:0]  RESET_PC = 9'o000,
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned DW       = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
`ifdef SIMPLEZ_STEP_EN
   input  logic          step,
`endif
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] acc,
   output logic          zflag,
   output logic          halted
);

   state_e        state_q;
   logic [8:0]    pc_q;
   logic [11:0]   ir_q;
   logic [11:0]   acc_q;
   logic [11:0]   opnd_q;
   logic          z_q;
   logic          halted_q;
`ifdef SIMPLEZ_STEP_EN
   logic          go_q;
`endif

   logic [2:0]    op;
   logic [8:0]    cd;
   logic [11:0]   alu_a;
   logic          alu_z;
   logic          fetch_rd;

   assign op = ir_op(ir_q);
   assign cd = ir_cd(ir_q);

`ifdef SIMPLEZ_STEP_EN
   assign fetch_rd = go_q;
`else
   assign fetch_rd = 1'b1;
`endif

   // Operand for LD/ADD is latched at the end of EXEC, so MEM never looks at the bus.
   simplez_alu #(
      .DW (12)
   ) u_alu (
      .a_i       (acc_q),
      .operand_i (opnd_q),
      .op_i      (op),
      .a_o       (alu_a),
      .z_o       (alu_z)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StInit;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         z_q      <= 1'b0;
         halted_q <= 1'b0;
`ifdef SIMPLEZ_STEP_EN
         go_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            StInit: state_q <= StFetch;
            StFetch: begin
`ifdef SIMPLEZ_STEP_EN
               if (!go_q) begin
                  if (step) go_q <= 1'b1;
               end else begin
                  go_q    <= 1'b0;
                  ir_q    <= mem_rdata;
                  state_q <= StDecode;
               end
`else
               ir_q    <= mem_rdata;
               state_q <= StDecode;
`endif
            end
            StDecode: begin
               pc_q    <= pc_q + 9'd1;
               state_q <= StExec;
            end
            StExec: begin
               state_q <= StFetch;
               case (op)
                  OP_ST: ;
                  OP_LD, OP_ADD: begin
                     opnd_q  <= mem_rdata;
                     state_q <= StMem;
                  end
                  OP_BR: pc_q <= cd;
                  OP_BZ: if (z_q) pc_q <= cd;
                  OP_CLR, OP_DEC: begin
                     acc_q <= alu_a;
                     z_q   <= alu_z;
                  end
                  OP_HALT: begin
                     halted_q <= 1'b1;
                     state_q  <= StHalt;
                  end
               endcase
            end
            StMem: begin
               acc_q   <= alu_a;
               z_q     <= alu_z;
               state_q <= StFetch;
            end
            StHalt: state_q <= StHalt;
            default: state_q <= StInit;
         endcase
      end
   end

   // Strobes decode straight from registered state so reset removes them immediately.
   always_comb begin
      mem_addr = pc_q;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      case (state_q)
         StFetch: mem_rd = fetch_rd;
         StExec: begin
            if (op == OP_ST) begin
               mem_addr = cd;
               mem_wr   = 1'b1;
            end else if (op == OP_LD || op == OP_ADD) begin
               mem_addr = cd;
               mem_rd   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign mem_wdata = acc_q;
   assign acc       = acc_q;
   assign zflag     = z_q;
   assign halted    = halted_q;

   a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst) !(mem_rd && mem_wr));

endmodule
